// File: rtl/spart_io_master.sv
// CPU-side initiator for the SPART I/O port: polls the status word, drains RX bytes into a
// one-entry holding register, pushes TX bytes, and aborts requests that never complete.
module spart_io_master #(
  parameter int unsigned PollInterval = 16,
  parameter int unsigned Timeout      = 1024,
  parameter logic [27:0] DataAddr     = 28'h800_0000,
  parameter logic [27:0] StatAddr     = 28'h800_0001
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        io_valid_data_o,
  output logic        io_rw_data_o,
  output logic [27:0] mem_addr_o,
  output logic [31:0] io_wr_data_o,
  input  logic        io_ready_data_i,
  input  logic [31:0] io_rd_data_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        timeout_err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StStatReq,
    StGap,
    StDecide,
    StRxReq,
    StTxReq
  } state_e;

  localparam logic [15:0] PollLast    = 16'(PollInterval - 1);
  localparam logic [15:0] TimeoutLast = 16'(Timeout - 1);

  state_e      state_q, state_d;
  state_e      gap_tgt_q, gap_tgt_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [1:0]  status_q, status_d;
  logic        valid_q, valid_d;
  logic        rw_q, rw_d;
  logic [27:0] addr_q, addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        tx_ready_q, tx_ready_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        err_q, err_d;

  logic done;
  logic expire;
  logic rx_free;

  logic unused_rd;
  assign unused_rd = ^io_rd_data_i[31:8];

  // Completion and timeout only mean anything while a request is actually on the bus.
  assign done    = valid_q & io_ready_data_i;
  assign expire  = valid_q & ~io_ready_data_i & (to_cnt_q == TimeoutLast);
  assign rx_free = ~rx_valid_q | rx_ready_i;

  always_comb begin
    state_d    = state_q;
    gap_tgt_d  = gap_tgt_q;
    poll_cnt_d = poll_cnt_q;
    to_cnt_d   = '0;
    status_d   = status_q;
    tx_ready_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready_i;
    err_d      = err_q;

    if (valid_q && !io_ready_data_i && !expire) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end

    case (state_q)
      StIdle: begin
        if (poll_cnt_q == PollLast) begin
          poll_cnt_d = '0;
          state_d    = StStatReq;
        end else begin
          poll_cnt_d = poll_cnt_q + 16'd1;
        end
      end
      StStatReq: begin
        if (done) begin
          status_d  = io_rd_data_i[1:0];
          gap_tgt_d = StDecide;
          state_d   = StGap;
        end else if (expire) begin
          err_d     = 1'b1;
          gap_tgt_d = StIdle;
          state_d   = StGap;
        end
      end
      StGap: begin
        state_d = gap_tgt_q;
      end
      StDecide: begin
        if (status_q[0] && rx_free) begin
          state_d = StRxReq;
        end else if (status_q[1] && tx_valid_i) begin
          state_d = StTxReq;
        end else begin
          state_d = StIdle;
        end
      end
      StRxReq: begin
        if (done) begin
          // A reload overrides a same-cycle consume.
          rx_data_d  = io_rd_data_i[7:0];
          rx_valid_d = 1'b1;
          gap_tgt_d  = StStatReq;
          state_d    = StGap;
        end else if (expire) begin
          err_d     = 1'b1;
          gap_tgt_d = StIdle;
          state_d   = StGap;
        end
      end
      StTxReq: begin
        if (done) begin
          tx_ready_d = 1'b1;
          gap_tgt_d  = StStatReq;
          state_d    = StGap;
        end else if (expire) begin
          err_d     = 1'b1;
          gap_tgt_d = StIdle;
          state_d   = StGap;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Request fields are registered from the next state, so they are stable for the
  // whole valid window and zero outside it.
  always_comb begin
    valid_d   = 1'b0;
    rw_d      = 1'b0;
    addr_d    = '0;
    wr_data_d = '0;
    case (state_d)
      StStatReq: begin
        valid_d = 1'b1;
        addr_d  = StatAddr;
      end
      StRxReq: begin
        valid_d = 1'b1;
        addr_d  = DataAddr;
      end
      StTxReq: begin
        valid_d   = 1'b1;
        rw_d      = 1'b1;
        addr_d    = DataAddr;
        wr_data_d = (state_q == StTxReq) ? wr_data_q : {24'd0, tx_data_i};
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      gap_tgt_q  <= StIdle;
      poll_cnt_q <= '0;
      to_cnt_q   <= '0;
      status_q   <= '0;
      valid_q    <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      tx_ready_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_tgt_q  <= gap_tgt_d;
      poll_cnt_q <= poll_cnt_d;
      to_cnt_q   <= to_cnt_d;
      status_q   <= status_d;
      valid_q    <= valid_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

  assign io_valid_data_o = valid_q;
  assign io_rw_data_o    = rw_q;
  assign mem_addr_o      = addr_q;
  assign io_wr_data_o    = wr_data_q;
  assign tx_ready_o      = tx_ready_q;
  assign rx_data_o       = rx_data_q;
  assign rx_valid_o      = rx_valid_q;
  assign timeout_err_o   = err_q;

endmodule

// File: tb/tb_spart_io_master.sv
// Directed bench for spart_io_master: a behavioural SPART responder plus table-driven
// scenarios and a few hand-written corner-case sequences.
module tb_spart_io_master;

  localparam logic [27:0] DataAddr = 28'h800_0000;
  localparam logic [27:0] StatAddr = 28'h800_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        io_valid, io_rw, io_ready = 1'b0;
  logic [27:0] mem_addr;
  logic [31:0] io_wr_data, io_rd_data = '0;
  logic [7:0]  tx_data = '0, rx_data;
  logic        tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0, timeout_err;

  always #5 clk = ~clk;

  spart_io_master #(
    .PollInterval(16),
    .Timeout     (8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .io_valid_data_o(io_valid),
    .io_rw_data_o   (io_rw),
    .mem_addr_o     (mem_addr),
    .io_wr_data_o   (io_wr_data),
    .io_ready_data_i(io_ready),
    .io_rd_data_i   (io_rd_data),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (rx_ready),
    .timeout_err_o  (timeout_err)
  );

  // Responder / monitor state
  int          lat = 1;
  bit          spur = 1'b0, hold_data = 1'b0;
  logic [31:0] stat_word = '0, data_word = '0;
  int          vcnt, cur_run, max_run, n_stat, n_drd, n_dwr, n_txr, n_vcyc, n_unstable;
  int          first_data;
  bit          got_first;
  logic [27:0] first_addr, p_addr;
  logic        first_rw, p_rw;
  logic [31:0] last_wd, p_wd;

  int total = 0;
  int bad = 0;

  task automatic clr();
    vcnt = 0; cur_run = 0; max_run = 0; n_stat = 0; n_drd = 0; n_dwr = 0; n_txr = 0;
    n_vcyc = 0; n_unstable = 0; first_data = -1; got_first = 1'b0; first_addr = '0;
    first_rw = 1'b0; last_wd = '0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      io_ready = 1'b0; vcnt = 0; cur_run = 0;
    end else if (io_valid) begin
      vcnt++; cur_run++; n_vcyc++;
      if (cur_run > max_run) max_run = cur_run;
      if (vcnt > 1 && (io_rw !== p_rw || mem_addr !== p_addr || io_wr_data !== p_wd))
        n_unstable++;
      p_rw = io_rw; p_addr = mem_addr; p_wd = io_wr_data;
      io_ready = spur || (lat != 0 && vcnt == lat && !(hold_data && mem_addr == DataAddr));
      io_rd_data = (mem_addr == DataAddr) ? data_word : stat_word;
      if (io_ready) begin
        if (!got_first) begin
          got_first = 1'b1; first_addr = mem_addr; first_rw = io_rw;
        end
        if (mem_addr == StatAddr && !io_rw) n_stat++;
        else if (mem_addr == DataAddr && !io_rw) begin
          n_drd++;
          if (first_data < 0) first_data = 0;
        end else if (mem_addr == DataAddr && io_rw) begin
          n_dwr++; last_wd = io_wr_data;
          if (first_data < 0) first_data = 1;
        end
      end
    end else begin
      vcnt = 0; cur_run = 0; io_ready = spur;
      io_rd_data = stat_word;
    end
    // Client side: one queued TX byte, dropped once accepted.
    if (rst_n && tx_ready) begin
      n_txr++; tx_valid = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    int          cycles;
    int          lat;
    bit          spur;
    logic [31:0] stat;
    logic [31:0] data;
    bit          txv;
    logic [7:0]  txd;
    bit          rxr;
    int          e_stat, e_drd, e_dwr, e_txr, e_vcyc, e_run;
    bit          e_rxv;
    logic [7:0]  e_rxd;
    bit          e_err;
    logic [31:0] e_wd;
    int          e_first;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{"idle_l1",   60, 1, 1'b0, 32'h0, 32'h0,  1'b0, 8'h00, 1'b0,
                3, 0, 0, 0, 3, 1, 1'b0, 8'h00, 1'b0, 32'h0, -1};
    vecs[1] = '{"idle_l2",   50, 2, 1'b0, 32'h0, 32'h0,  1'b0, 8'h00, 1'b0,
                2, 0, 0, 0, 4, 2, 1'b0, 8'h00, 1'b0, 32'h0, -1};
    vecs[2] = '{"idle_spur", 60, 1, 1'b1, 32'h0, 32'h0,  1'b0, 8'h00, 1'b0,
                3, 0, 0, 0, 3, 1, 1'b0, 8'h00, 1'b0, 32'h0, -1};
    vecs[3] = '{"rx_hold",   50, 1, 1'b0, 32'h1, 32'hA5, 1'b0, 8'h00, 1'b0,
                3, 1, 0, 0, 4, 1, 1'b1, 8'hA5, 1'b0, 32'h0, 0};
    vecs[4] = '{"tx",        50, 1, 1'b0, 32'h2, 32'h0,  1'b1, 8'h3C, 1'b0,
                3, 0, 1, 1, 4, 1, 1'b0, 8'h00, 1'b0, 32'h3C, 1};
    vecs[5] = '{"rx_tx",     50, 1, 1'b0, 32'h3, 32'h5A, 1'b1, 8'h3C, 1'b0,
                4, 1, 1, 1, 6, 1, 1'b1, 8'h5A, 1'b0, 32'h3C, 0};
    vecs[6] = '{"rx_stream", 50, 1, 1'b0, 32'h1, 32'hC3, 1'b0, 8'h00, 1'b1,
                7, 7, 0, 0, 14, 1, 1'b0, 8'hC3, 1'b0, 32'h0, 0};
    vecs[7] = '{"tx_l2",     50, 2, 1'b0, 32'h2, 32'h0,  1'b1, 8'h81, 1'b0,
                3, 0, 1, 1, 8, 2, 1'b0, 8'h00, 1'b0, 32'h81, 1};
    vecs[8] = '{"timeout",   50, 0, 1'b0, 32'h2, 32'h0,  1'b1, 8'h77, 1'b0,
                0, 0, 0, 0, 16, 8, 1'b0, 8'h00, 1'b1, 32'h0, -1};

    // Asynchronous reset values, checked before any clock edge.
    clr();
    #1 rst_n = 1'b0;
    #2;
    chk("rst.valid", 32'(io_valid), 32'h0);
    chk("rst.rw", 32'(io_rw), 32'h0);
    chk("rst.addr", 32'(mem_addr), 32'h0);
    chk("rst.wdata", io_wr_data, 32'h0);
    chk("rst.tx_ready", 32'(tx_ready), 32'h0);
    chk("rst.rx_valid", 32'(rx_valid), 32'h0);
    chk("rst.rx_data", 32'(rx_data), 32'h0);
    chk("rst.err", 32'(timeout_err), 32'h0);

    for (int i = 0; i < 9; i++) begin
      stat_word = vecs[i].stat; data_word = vecs[i].data; lat = vecs[i].lat;
      spur = vecs[i].spur; hold_data = 1'b0; tx_valid = vecs[i].txv;
      tx_data = vecs[i].txd; rx_ready = vecs[i].rxr;
      do_reset();
      repeat (vecs[i].cycles) @(posedge clk);
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".stat_rd"}, n_stat, vecs[i].e_stat);
      chk({vecs[i].name, ".data_rd"}, n_drd, vecs[i].e_drd);
      chk({vecs[i].name, ".data_wr"}, n_dwr, vecs[i].e_dwr);
      chk({vecs[i].name, ".tx_ready"}, n_txr, vecs[i].e_txr);
      chk({vecs[i].name, ".valid_cyc"}, n_vcyc, vecs[i].e_vcyc);
      chk({vecs[i].name, ".max_run"}, max_run, vecs[i].e_run);
      chk({vecs[i].name, ".rx_valid"}, 32'(rx_valid), 32'(vecs[i].e_rxv));
      chk({vecs[i].name, ".rx_data"}, 32'(rx_data), 32'(vecs[i].e_rxd));
      chk({vecs[i].name, ".err"}, 32'(timeout_err), 32'(vecs[i].e_err));
      chk({vecs[i].name, ".wdata"}, last_wd, vecs[i].e_wd);
      chk({vecs[i].name, ".first_data"}, first_data, vecs[i].e_first);
      chk({vecs[i].name, ".unstable"}, n_unstable, 0);
    end

    // RX back-pressure: no second data read until the held byte is consumed.
    stat_word = 32'h1; data_word = 32'hA5; lat = 1; spur = 1'b0; hold_data = 1'b0;
    tx_valid = 1'b0; rx_ready = 1'b0;
    do_reset();
    repeat (60) @(posedge clk);
    @(posedge clk);
    #1;
    chk("bp.held_reads", n_drd, 1);
    chk("bp.held_valid", 32'(rx_valid), 32'h1);
    data_word = 32'h11;
    @(negedge clk) rx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.consumed", 32'(rx_valid), 32'h0);
    @(negedge clk) rx_ready = 1'b0;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(posedge clk);
        #1;
        if (n_drd == 2) seen = 1'b1;
      end
      chk("bp.second_read", n_drd, 2);
      chk("bp.reload_valid", 32'(rx_valid), 32'h1);
      chk("bp.reload_data", 32'(rx_data), 32'h11);
    end

    // Timeout is sticky and polling resumes once the responder recovers.
    stat_word = 32'h0; lat = 0; tx_valid = 1'b0;
    do_reset();
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(posedge clk);
        #1;
        if (timeout_err) seen = 1'b1;
      end
      chk("to.err_set", 32'(timeout_err), 32'h1);
    end
    lat = 1;
    repeat (40) @(posedge clk);
    #1;
    chk("to.err_sticky", 32'(timeout_err), 32'h1);
    chk("to.resumed", 32'(n_stat > 0), 32'h1);
    chk("to.no_data", n_drd + n_dwr, 0);

    // Asynchronous reset in the middle of a stalled TX request.
    stat_word = 32'h2; lat = 1; hold_data = 1'b1; tx_data = 8'hE7; tx_valid = 1'b1;
    do_reset();
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(posedge clk);
        #1;
        if (io_valid && io_rw) seen = 1'b1;
      end
      chk("ar.tx_seen", 32'(seen), 32'h1);
      chk("ar.tx_addr", 32'(mem_addr), 32'(DataAddr));
      chk("ar.tx_wdata", io_wr_data, 32'h0000_00E7);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid_drop", 32'(io_valid), 32'h0);
    chk("ar.rw_drop", 32'(io_rw), 32'h0);
    chk("ar.no_tx_ready", n_txr, 0);
    clr();
    hold_data = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(posedge clk);
        #1;
        if (got_first) seen = 1'b1;
      end
      chk("ar.first_seen", 32'(seen), 32'h1);
      chk("ar.first_addr", 32'(first_addr), 32'(StatAddr));
      chk("ar.first_rw", 32'(first_rw), 32'h0);
      chk("ar.tx_not_taken", n_txr, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
